// File: rtl/cla_seq32.sv
// Sequential 32-bit add/subtract unit: eight nibble passes through one 4-bit
// carry-lookahead adder, with registered result and NZCV-style flags.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is formed directly from g/p/ci, so no carry ripples between bits.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

module cla_seq32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        co,
    output logic        ov,
    output logic        z,
    output logic        n,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] work;
    logic [2:0]  idx;
    logic        carry;
    logic [3:0]  nib_s;
    logic        nib_co;
    logic        accept;
    logic [31:0] sum_full;

    cla4 u_cla4 (
        .a  (a_q[{idx, 2'b00} +: 4]),
        .b  (b_q[{idx, 2'b00} +: 4]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    // A start arriving mid-RUN is dropped, not queued.
    assign accept   = start && (state != RUN);
    assign sum_full = {nib_s, work[27:0]};

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (idx == 3'd7) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            ov     <= 1'b0;
            z      <= 1'b1;
            n      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q   <= a;
                b_q   <= b ^ {32{op}};
                idx   <= '0;
                carry <= op;
            end else if (state == RUN) begin
                work[{idx, 2'b00} +: 4] <= nib_s;
                carry                   <= nib_co;
                if (idx != 3'd7) begin
                    idx <= idx + 3'd1;
                end else begin
                    // Last nibble: publish the assembled sum and flags in one step.
                    result <= sum_full;
                    co     <= nib_co;
                    ov     <= (a_q[31] == b_q[31]) && (nib_s[3] != a_q[31]);
                    z      <= (sum_full == 32'd0);
                    n      <= nib_s[3];
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_seq32.sv
// Self-checking bench for cla_seq32: directed corner cases plus randomized
// operations compared against an arithmetic reference model.

module tb_cla_seq32;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] r;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t held;

    cla_seq32 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .co     (co),
        .ov     (ov),
        .z      (z),
        .n      (n),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint sr;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        sr   = o ? (sx - sy) : (sx + sy);
        e.r  = o ? (x - y) : (x + y);
        e.co = o ? (x >= y) : ((longint'(x) + longint'(y)) > 64'hFFFF_FFFF);
        e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z  = (e.r == 32'd0);
        e.n  = e.r[31];
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".result"}, result, e.r);
        check({tag, ".co"}, {31'd0, co}, {31'd0, e.co});
        check({tag, ".ov"}, {31'd0, ov}, {31'd0, e.ov});
        check({tag, ".z"}, {31'd0, z}, {31'd0, e.z});
        check({tag, ".n"}, {31'd0, n}, {31'd0, e.n});
    endtask

    // Called in cycle 0; returns in the done cycle (cycle 9) with start low.
    // ign_cycle != 0 pulses a conflicting start in that RUN cycle.
    task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                         input logic [31:0] y, input int ign_cycle);
        exp_t e;
        e     = model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check({tag, ".busy"}, {31'd0, busy}, 32'd1);
            check({tag, ".done_run"}, {31'd0, done}, 32'd0);
            check({tag, ".hold"}, result, held.r);
            start = (c == ign_cycle);
            op    = 1'($urandom);
            a     = (c == ign_cycle) ? 32'hFFFF_FFFF : $urandom;
            b     = (c == ign_cycle) ? 32'd1 : $urandom;
            if (c == ign_cycle) op = 1'b0;
            tick();
        end
        start = 1'b0;
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        check_outputs(tag, e);
        held = e;
    endtask

    task automatic go_idle(input string tag);
        start = 1'b0;
        tick();
        check({tag, ".done_clr"}, {31'd0, done}, 32'd0);
        check({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
        check_outputs({tag, ".held"}, held);
    endtask

    initial begin
        exp_t zero_e;
        zero_e = '{r: 32'd0, co: 1'b0, ov: 1'b0, z: 1'b1, n: 1'b0};
        held   = zero_e;
        reset  = 1'b1;
        start  = 1'b1;
        op     = 1'b0;
        a      = 32'h1234_5678;
        b      = 32'h1;
        tick();
        tick();
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check_outputs("rst", zero_e);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post_rst.busy", {31'd0, busy}, 32'd0);

        do_op("add_wrap", 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 0);
        go_idle("add_wrap");
        do_op("sub_neg", 1'b1, 32'd5, 32'd7, 0);
        go_idle("sub_neg");
        do_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 0);
        go_idle("add_ovf");
        do_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 0);
        go_idle("sub_ovf");

        do_op("ign_start", 1'b0, 32'h10, 32'h20, 4);
        check("ign_start.value", result, 32'h30);
        for (int c = 0; c < 12; c++) begin
            start = 1'b0;
            tick();
            check("ign_start.no_done", {31'd0, done}, 32'd0);
            check("ign_start.no_busy", {31'd0, busy}, 32'd0);
        end

        // Reset in RUN cycle 5.
        start = 1'b1;
        op    = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0101_0101;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check("mid_rst.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst.busy", {31'd0, busy}, 32'd0);
        check("mid_rst.done", {31'd0, done}, 32'd0);
        held = zero_e;
        check_outputs("mid_rst", zero_e);
        do_op("after_rst", 1'b0, 32'd3, 32'd4, 0);
        check("after_rst.value", result, 32'd7);

        // Back-to-back: start held in the done cycle.
        go_idle("pre_b2b");
        do_op("b2b_first", 1'b0, 32'h1, 32'h2, 0);
        do_op("b2b_second", 1'b0, 32'hA, 32'hB, 0);
        check("b2b_second.value", result, 32'h15);
        go_idle("b2b");

        for (int k = 0; k < 40; k++) begin
            do_op("rand", 1'($urandom), $urandom, $urandom, 0);
            if ($urandom_range(0, 1) == 0) go_idle("rand");
        end
        do_op("same_sub", 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        go_idle("same_sub");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
